// File: rtl/botones_antirebote_multi_pkg.sv
// Shared definitions for the multi-channel button conditioner: FSM state
// encoding and the counter width helper.
package botones_antirebote_multi_pkg;

  localparam logic [1:0] ST_REPOSO     = 2'd0;
  localparam logic [1:0] ST_CONFIRMA_P = 2'd1;
  localparam logic [1:0] ST_PRESIONADO = 2'd2;
  localparam logic [1:0] ST_CONFIRMA_L = 2'd3;

  typedef enum logic [1:0] {
    REPOSO     = ST_REPOSO,
    CONFIRMA_P = ST_CONFIRMA_P,
    PRESIONADO = ST_PRESIONADO,
    CONFIRMA_L = ST_CONFIRMA_L
  } estado_t;

  // Wide enough to hold the larger of the debounce window and the long-press limit.
  function automatic int cnt_width(input int debounce, input int largo);
    int mayor;
    mayor = (debounce > largo) ? debounce : largo;
    return $clog2(mayor + 1);
  endfunction

endpackage

// File: rtl/botones_antirebote_multi_canal.sv
// One button channel: synchroniser, debounce FSM, hold counter and
// registered level/strobe outputs.
module canal_antirebote
  import botones_antirebote_multi_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 250000000,
  parameter int SYNC_STAGES       = 2,
  parameter int ACTIVE_LOW_IN     = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic estable,
  output logic pulso_presion,
  output logic pulso_liberacion,
  output logic pulso_largo,
  output logic pulso_corto,
  output logic es_largo
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] UNO       = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_FIN   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  // Registered strobe lands in the cycle the hold counter reads LONG_PRESS_CYCLES-1.
  localparam logic [CNT_W-1:0] LARGO_OBJ =
    (LONG_PRESS_CYCLES > 1) ? CNT_W'(LONG_PRESS_CYCLES - 1) : UNO;

  logic [SYNC_STAGES-1:0] sync;
  logic                   crudo;
  logic                   p;
  estado_t                estado;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       hold;
  logic [CNT_W-1:0]       hold_sig;

  assign crudo    = (ACTIVE_LOW_IN != 0) ? ~boton : boton;
  assign p        = sync[SYNC_STAGES-1];
  assign hold_sig = (hold == HOLD_MAX) ? hold : hold + UNO;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], crudo};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado           <= REPOSO;
      cnt              <= '0;
      hold             <= '0;
      estable          <= 1'b0;
      es_largo         <= 1'b0;
      pulso_presion    <= 1'b0;
      pulso_liberacion <= 1'b0;
      pulso_largo      <= 1'b0;
      pulso_corto      <= 1'b0;
    end else begin
      pulso_presion    <= 1'b0;
      pulso_liberacion <= 1'b0;
      pulso_largo      <= 1'b0;
      pulso_corto      <= 1'b0;
      case (estado)
        REPOSO: begin
          if (p) begin
            estado <= CONFIRMA_P;
            cnt    <= UNO;
          end
        end
        CONFIRMA_P: begin
          if (!p) begin
            estado <= REPOSO;
            cnt    <= '0;
          end else if (cnt == DEB_FIN) begin
            estado        <= PRESIONADO;
            cnt           <= '0;
            hold          <= '0;
            estable       <= 1'b1;
            pulso_presion <= 1'b1;
          end else begin
            cnt <= cnt + UNO;
          end
        end
        PRESIONADO: begin
          hold <= hold_sig;
          if (hold_sig == LARGO_OBJ && !es_largo) begin
            pulso_largo <= 1'b1;
            es_largo    <= 1'b1;
          end
          if (!p) begin
            estado <= CONFIRMA_L;
            cnt    <= UNO;
          end
        end
        CONFIRMA_L: begin
          // A glitch back to pressed resumes the hold count rather than restarting it.
          if (p) begin
            estado <= PRESIONADO;
            cnt    <= '0;
          end else if (cnt == DEB_FIN) begin
            estado           <= REPOSO;
            cnt              <= '0;
            estable          <= 1'b0;
            es_largo         <= 1'b0;
            pulso_liberacion <= 1'b1;
            pulso_corto      <= ~es_largo;
          end else begin
            cnt <= cnt + UNO;
          end
        end
        default: begin
          estado <= REPOSO;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/botones_antirebote_multi.sv
// N-channel button conditioner: one independent canal_antirebote per pin,
// outputs gathered into per-function vectors.
module botones_antirebote_multi
  import botones_antirebote_multi_pkg::*;
#(
  parameter int N_CANALES         = 4,
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 250000000,
  parameter int SYNC_STAGES       = 2,
  parameter int ACTIVE_LOW_IN     = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CANALES-1:0] botones,
  output logic [N_CANALES-1:0] estable,
  output logic [N_CANALES-1:0] pulso_presion,
  output logic [N_CANALES-1:0] pulso_liberacion,
  output logic [N_CANALES-1:0] pulso_largo,
  output logic [N_CANALES-1:0] pulso_corto,
  output logic [N_CANALES-1:0] es_largo
);

  for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
    canal_antirebote #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .SYNC_STAGES      (SYNC_STAGES),
      .ACTIVE_LOW_IN    (ACTIVE_LOW_IN)
    ) u_canal (
      .clk             (clk),
      .reset           (reset),
      .boton           (botones[i]),
      .estable         (estable[i]),
      .pulso_presion   (pulso_presion[i]),
      .pulso_liberacion(pulso_liberacion[i]),
      .pulso_largo     (pulso_largo[i]),
      .pulso_corto     (pulso_corto[i]),
      .es_largo        (es_largo[i])
    );
  end

endmodule

// File: tb/tb_botones_antirebote_multi.sv
// Bench for botones_antirebote_multi: directed scenarios plus random pin
// activity, every cycle compared against a run-length reference model.
module tb_botones_antirebote_multi;

  localparam int N    = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] botones;
  logic [N-1:0] estable, pulso_presion, pulso_liberacion, pulso_largo, pulso_corto, es_largo;

  botones_antirebote_multi #(
    .N_CANALES        (N),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .SYNC_STAGES      (SYNC),
    .ACTIVE_LOW_IN    (1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .botones         (botones),
    .estable         (estable),
    .pulso_presion   (pulso_presion),
    .pulso_liberacion(pulso_liberacion),
    .pulso_largo     (pulso_largo),
    .pulso_corto     (pulso_corto),
    .es_largo        (es_largo)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a pressed-bit delay line, an accepted level, and the
  // length of the current run of samples disagreeing with that level.
  logic [SYNC-1:0] m_sh [N];
  int              m_run [N];
  int              m_hold [N];
  logic [N-1:0]    m_lvl, m_pres, m_lib, m_largo, m_corto, m_eslargo;

  task model_clear();
    for (int c = 0; c < N; c++) begin
      m_sh[c]   = '0;
      m_run[c]  = 0;
      m_hold[c] = 0;
    end
    m_lvl = '0; m_pres = '0; m_lib = '0; m_largo = '0; m_corto = '0; m_eslargo = '0;
  endtask

  task model_edge();
    logic p;
    int   old;
    m_pres = '0; m_lib = '0; m_largo = '0; m_corto = '0;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int c = 0; c < N; c++) begin
      p        = m_sh[c][SYNC-1];
      m_sh[c]  = {m_sh[c][SYNC-2:0], ~botones[c]};
      old      = m_run[c];
      m_run[c] = (p != m_lvl[c]) ? old + 1 : 0;
      // Hold time advances only while pressed and not already doubting the release.
      if (m_lvl[c] && old == 0) begin
        if (m_hold[c] < LONG) m_hold[c]++;
        if (m_hold[c] == LONG - 1 && !m_eslargo[c]) begin
          m_largo[c]   = 1'b1;
          m_eslargo[c] = 1'b1;
        end
      end
      if (m_run[c] == DEB) begin
        m_run[c] = 0;
        if (!m_lvl[c]) begin
          m_lvl[c]  = 1'b1;
          m_pres[c] = 1'b1;
          m_hold[c] = 0;
        end else begin
          m_lvl[c]     = 1'b0;
          m_lib[c]     = 1'b1;
          m_corto[c]   = ~m_eslargo[c];
          m_eslargo[c] = 1'b0;
        end
      end
    end
  endtask

  task compare_all();
    chk("estable", 32'(estable), 32'(m_lvl));
    chk("pulso_presion", 32'(pulso_presion), 32'(m_pres));
    chk("pulso_liberacion", 32'(pulso_liberacion), 32'(m_lib));
    chk("pulso_largo", 32'(pulso_largo), 32'(m_largo));
    chk("pulso_corto", 32'(pulso_corto), 32'(m_corto));
    chk("es_largo", 32'(es_largo), 32'(m_eslargo));
  endtask

  // Event bookkeeping for the directed scenarios.
  int           stepn;
  int           f_pres [N], f_lib [N], f_largo [N], n_largo [N], n_lib [N];
  logic [N-1:0] act, first_vec;

  task clear_watch();
    stepn = 0; act = '0; first_vec = '0;
    for (int c = 0; c < N; c++) begin
      f_pres[c] = -1; f_lib[c] = -1; f_largo[c] = -1; n_largo[c] = 0; n_lib[c] = 0;
    end
  endtask

  task run_watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      stepn++;
      act |= estable | pulso_presion | pulso_liberacion | pulso_largo | pulso_corto | es_largo;
      if (pulso_presion != '0 && first_vec == '0) first_vec = pulso_presion;
      for (int c = 0; c < N; c++) begin
        if (pulso_presion[c] && f_pres[c] < 0) f_pres[c] = stepn;
        if (pulso_liberacion[c] && f_lib[c] < 0) f_lib[c] = stepn;
        if (pulso_largo[c] && f_largo[c] < 0) f_largo[c] = stepn;
        if (pulso_largo[c]) n_largo[c]++;
        if (pulso_liberacion[c]) n_lib[c]++;
      end
    end
  endtask

  task assert_reset_now();
    reset = 1'b0;
    #1;
    model_clear();
    compare_all();
    chk("reset_all_zero", 32'(estable | pulso_presion | pulso_liberacion | pulso_largo |
                              pulso_corto | es_largo), 32'd0);
  endtask

  initial begin
    reset   = 1'b0;
    botones = '1;
    model_clear();
    #2;
    chk("reset_all_zero", 32'(estable | pulso_presion | pulso_liberacion | pulso_largo |
                              pulso_corto | es_largo), 32'd0);
    clear_watch();
    run_watch(3);
    reset = 1'b1;
    run_watch(5);

    // Clean short press on ch0
    clear_watch();
    botones[0] = 1'b0;
    run_watch(20);
    chk("ch0_press_latency", 32'(f_pres[0]), 32'd10);
    chk("ch0_no_long_held", 32'(n_largo[0]), 32'd0);
    clear_watch();
    botones[0] = 1'b1;
    run_watch(15);
    chk("ch0_release_latency", 32'(f_lib[0]), 32'd10);
    chk("ch0_no_long", 32'(n_largo[0]), 32'd0);

    // Bounce on ch1 shorter than the window
    clear_watch();
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) botones[1] = ~botones[1];
      run_watch(1);
    end
    botones[1] = 1'b1;
    run_watch(20);
    chk("ch1_bounce_silent", 32'(act[1]), 32'd0);

    // Long hold on ch2
    clear_watch();
    botones[2] = 1'b0;
    run_watch(60);
    chk("ch2_long_delay", 32'(f_largo[2] - f_pres[2]), 32'd31);
    chk("ch2_long_once", 32'(n_largo[2]), 32'd1);
    chk("ch2_es_largo_held", 32'(es_largo[2]), 32'd1);
    botones[2] = 1'b1;
    run_watch(15);
    chk("ch2_release_count", 32'(n_lib[2]), 32'd1);

    // Release glitch on ch3
    clear_watch();
    botones[3] = 1'b0;
    run_watch(20);
    botones[3] = 1'b1;
    run_watch(4);
    botones[3] = 1'b0;
    run_watch(30);
    chk("ch3_no_release", 32'(n_lib[3]), 32'd0);
    chk("ch3_long_once", 32'(n_largo[3]), 32'd1);
    botones[3] = 1'b1;
    run_watch(15);

    // Simultaneous press on ch0 and ch3
    clear_watch();
    botones = 4'b0110;
    run_watch(15);
    chk("simul_press_vec", 32'(first_vec), 32'h9);
    chk("simul_press_lat", 32'(f_pres[3]), 32'd10);
    botones = '1;
    run_watch(15);

    // Reset in the middle of a long hold on ch2
    clear_watch();
    botones[2] = 1'b0;
    run_watch(45);
    chk("ch2_long_before_reset", 32'(es_largo[2]), 32'd1);
    botones[2] = 1'b1;
    assert_reset_now();
    run_watch(3);
    reset = 1'b1;
    clear_watch();
    run_watch(20);
    chk("after_reset_silent", 32'(act), 32'd0);

    // Button held through reset release
    assert_reset_now();
    botones[1] = 1'b0;
    run_watch(3);
    reset = 1'b1;
    clear_watch();
    run_watch(15);
    chk("held_reset_press_lat", 32'(f_pres[1]), 32'd10);
    botones[1] = 1'b1;
    run_watch(15);

    // Random pin activity on all channels
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 19) == 0) botones[c] = ~botones[c];
      run_watch(1);
    end
    botones = '1;
    run_watch(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
